// File: rtl/beta_pkg.sv
// beta_pkg
// Shared definitions for the Beta-style EX/MEM/WB bypass pipeline.
//   ir_tag_t  : 15-bit instruction tag carried down the pipe (Rc at [14:10])
//   BUBBLE_IR : tag of an injected no-op; its Rc is R31, which always reads as zero
//   REG_ZERO  : register number that is never written
//   RC_MSB/RC_LSB : location of the destination register field in a tag
//   rc_of()   : extracts the destination register from a tag
package beta_pkg;

    localparam int RC_MSB = 14;
    localparam int RC_LSB = 10;

    typedef logic [14:0] ir_tag_t;

    localparam logic [4:0] REG_ZERO  = 5'd31;
    localparam ir_tag_t    BUBBLE_IR = 15'h7C00;

    // Destination register of an instruction tag.
    function automatic logic [4:0] rc_of(input ir_tag_t ir);
        return ir[RC_MSB:RC_LSB];
    endfunction

endpackage

// File: rtl/bypass_pipe_if.sv
// bypass_pipe_if
// Bundles every signal between the decode/exec/memory side of the CPU and the
// bypass pipeline.
//   decode side -> pipe : dec_ir, dec_is_ld, stall, annul, alu_result, mem_rdata
//   pipe -> consumers   : ir_exec/mem/wb, op_ld_or_ldr_exec/mem/wb,
//                         exec/mem/wb_bypass, we/wa/wd, retired, bubbles
// modport master : the surrounding CPU (drives decode-side inputs)
// modport slave  : the bypass pipeline itself
interface bypass_pipe_if;
    import beta_pkg::*;

    ir_tag_t     dec_ir;
    logic        dec_is_ld;
    logic        stall;
    logic        annul;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;

    ir_tag_t     ir_exec;
    ir_tag_t     ir_mem;
    ir_tag_t     ir_wb;
    logic        op_ld_or_ldr_exec;
    logic        op_ld_or_ldr_mem;
    logic        op_ld_or_ldr_wb;
    logic [31:0] exec_bypass;
    logic [31:0] mem_bypass;
    logic [31:0] wb_bypass;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] retired;
    logic [31:0] bubbles;

    modport master (
        output dec_ir, dec_is_ld, stall, annul, alu_result, mem_rdata,
        input  ir_exec, ir_mem, ir_wb,
        input  op_ld_or_ldr_exec, op_ld_or_ldr_mem, op_ld_or_ldr_wb,
        input  exec_bypass, mem_bypass, wb_bypass,
        input  we, wa, wd, retired, bubbles
    );

    modport slave (
        input  dec_ir, dec_is_ld, stall, annul, alu_result, mem_rdata,
        output ir_exec, ir_mem, ir_wb,
        output op_ld_or_ldr_exec, op_ld_or_ldr_mem, op_ld_or_ldr_wb,
        output exec_bypass, mem_bypass, wb_bypass,
        output we, wa, wd, retired, bubbles
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// One always-advancing pipeline stage register (used for MEM and WB).
//   clk, rst  : clock and synchronous active-high reset
//   tag_in    : instruction tag from the previous stage
//   ld_in     : previous stage holds LD/LDR
//   result_in : 32-bit result to carry forward
//   tag_q, ld_q, result_q : registered copies; reset to a bubble with zero result
module pipe_stage_reg
    import beta_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  ir_tag_t     tag_in,
    input  logic        ld_in,
    input  logic [31:0] result_in,
    output ir_tag_t     tag_q,
    output logic        ld_q,
    output logic [31:0] result_q
);

    // Stages after EX never stall, so this register loads every cycle.
    // Reset turns the stage into a bubble so nothing in flight can write back.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q    <= BUBBLE_IR;
            ld_q     <= 1'b0;
            result_q <= '0;
        end else begin
            tag_q    <= tag_in;
            ld_q     <= ld_in;
            result_q <= result_in;
        end
    end

endmodule

// File: rtl/bypass_pipe.sv
// bypass_pipe
// EX -> MEM -> WB tail of a Beta-style pipeline: carries instruction tags and
// load flags, provides the three forwarding values, drives the register-file
// write port and keeps retired/bubble counters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : bypass_pipe_if.slave (decode inputs, stage tags, bypasses,
//              register-file write port, counters)
module bypass_pipe
    import beta_pkg::*;
(
    input logic          clk,
    input logic          rst,
    bypass_pipe_if.slave bus
);

    logic        inject_bubble;
    logic        wb_valid;
    logic [31:0] mem_result;
    logic [31:0] wb_result;

    // A stall and an annul in the same cycle still produce only one bubble,
    // since both just replace the single instruction entering EX.
    assign inject_bubble = bus.stall | bus.annul;

    // EX stage: take the decode instruction unless it is held back or killed,
    // in which case a bubble (Rc=R31, not a load) enters instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ir_exec           <= BUBBLE_IR;
            bus.op_ld_or_ldr_exec <= 1'b0;
        end else if (inject_bubble) begin
            bus.ir_exec           <= BUBBLE_IR;
            bus.op_ld_or_ldr_exec <= 1'b0;
        end else begin
            bus.ir_exec           <= bus.dec_ir;
            bus.op_ld_or_ldr_exec <= bus.dec_is_ld;
        end
    end

    // MEM stage captures the ALU result of the instruction leaving EX.
    pipe_stage_reg u_mem (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (bus.ir_exec),
        .ld_in     (bus.op_ld_or_ldr_exec),
        .result_in (bus.alu_result),
        .tag_q     (bus.ir_mem),
        .ld_q      (bus.op_ld_or_ldr_mem),
        .result_q  (mem_result)
    );

    // WB stage just delays the MEM result one more cycle.
    pipe_stage_reg u_wb (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (bus.ir_mem),
        .ld_in     (bus.op_ld_or_ldr_mem),
        .result_in (mem_result),
        .tag_q     (bus.ir_wb),
        .ld_q      (bus.op_ld_or_ldr_wb),
        .result_q  (wb_result)
    );

    // Forwarding values. Loads only have real data in WB, where the
    // synchronous RAM output replaces the (meaningless) address result.
    assign bus.exec_bypass = bus.alu_result;
    assign bus.mem_bypass  = mem_result;
    assign bus.wb_bypass   = bus.op_ld_or_ldr_wb ? bus.mem_rdata : wb_result;

    // Register-file write port. R31 is hard-wired zero, so bubbles and
    // Rc=R31 instructions never write.
    assign wb_valid = (rc_of(bus.ir_wb) != REG_ZERO);
    assign bus.we   = wb_valid;
    assign bus.wa   = rc_of(bus.ir_wb);
    assign bus.wd   = bus.wb_bypass;

    // Counters: an instruction retires on the edge it leaves WB; bubbles are
    // counted as they are injected into EX. Reset wins over stall/annul.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.retired <= '0;
            bus.bubbles <= '0;
        end else begin
            bus.retired <= bus.retired + {31'd0, wb_valid};
            bus.bubbles <= bus.bubbles + {31'd0, inject_bubble};
        end
    end

endmodule

// File: tb/tb_bypass_pipe.sv
// tb_bypass_pipe
// Self-checking bench for bypass_pipe: directed vector table, reset corner
// sequences and randomized traffic compared against an instruction-level model.
module tb_bypass_pipe;
    import beta_pkg::*;

    localparam logic [14:0] TB_BUBBLE = 15'h7C00;
    localparam logic [14:0] TB_IDLE   = 15'h7C00;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bypass_pipe_if bus ();

    bypass_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: one record per instruction currently in EX, MEM, WB.
    typedef struct {
        logic [14:0] tag;
        logic        ld;
        logic [31:0] res;
    } slot_t;

    slot_t       m_slot [3];
    logic [31:0] m_retired;
    logic [31:0] m_bubbles;

    typedef struct {
        logic [14:0] dec_ir;
        logic        is_ld;
        logic        stall;
        logic        annul;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [14:0] e_ir_exec;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [31:0] e_mem;
        logic [31:0] e_retired;
        logic [31:0] e_bubbles;
    } vec_t;

    vec_t vecs [9];

    task automatic compareValue(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [14:0] ir, input logic ld,
                                 input logic st, input logic an,
                                 input logic [31:0] alu, input logic [31:0] rd,
                                 input logic r);
        @(negedge clk);
        bus.dec_ir     = ir;
        bus.dec_is_ld  = ld;
        bus.stall      = st;
        bus.annul      = an;
        bus.alu_result = alu;
        bus.mem_rdata  = rd;
        rst            = r;
    endtask

    // Advance the model by one clock using the inputs this bench drove.
    task automatic modelUpdate();
        logic kill;
        kill = bus.stall | bus.annul;
        if (rst) begin
            for (int i = 0; i < 3; i++) m_slot[i] = '{TB_BUBBLE, 1'b0, 32'd0};
            m_retired = 32'd0;
            m_bubbles = 32'd0;
        end else begin
            if (m_slot[2].tag[14:10] != 5'd31) m_retired = m_retired + 32'd1;
            if (kill) m_bubbles = m_bubbles + 32'd1;
            m_slot[2] = m_slot[1];
            m_slot[1] = '{m_slot[0].tag, m_slot[0].ld, bus.alu_result};
            if (kill) m_slot[0] = '{TB_BUBBLE, 1'b0, 32'd0};
            else      m_slot[0] = '{bus.dec_ir, bus.dec_is_ld, 32'd0};
        end
    endtask

    task automatic clockEdge();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic checkOutput();
        logic [31:0] exp_wb;
        logic [4:0]  exp_wa;
        exp_wb = m_slot[2].ld ? bus.mem_rdata : m_slot[2].res;
        exp_wa = m_slot[2].tag[14:10];
        compareValue("ir_exec", {17'd0, bus.ir_exec}, {17'd0, m_slot[0].tag});
        compareValue("ir_mem",  {17'd0, bus.ir_mem},  {17'd0, m_slot[1].tag});
        compareValue("ir_wb",   {17'd0, bus.ir_wb},   {17'd0, m_slot[2].tag});
        compareValue("ld_exec", {31'd0, bus.op_ld_or_ldr_exec}, {31'd0, m_slot[0].ld});
        compareValue("ld_mem",  {31'd0, bus.op_ld_or_ldr_mem},  {31'd0, m_slot[1].ld});
        compareValue("ld_wb",   {31'd0, bus.op_ld_or_ldr_wb},   {31'd0, m_slot[2].ld});
        compareValue("exec_bypass", bus.exec_bypass, bus.alu_result);
        compareValue("mem_bypass",  bus.mem_bypass,  m_slot[1].res);
        compareValue("wb_bypass",   bus.wb_bypass,   exp_wb);
        compareValue("we", {31'd0, bus.we}, {31'd0, (exp_wa != 5'd31)});
        compareValue("wa", {27'd0, bus.wa}, {27'd0, exp_wa});
        compareValue("wd", bus.wd, exp_wb);
        compareValue("retired", bus.retired, m_retired);
        compareValue("bubbles", bus.bubbles, m_bubbles);
    endtask

    initial begin
        // Directed sequence starting right after reset + idle.
        // A: Rc=3, B: load Rc=5, C: Rc=7, D: Rc=9.
        vecs[0] = '{15'h0C01, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        15'h0C01, 1'b0, 5'd31, 32'h0,        32'h0,    32'd0, 32'd0};
        vecs[1] = '{15'h1402, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0,        15'h1402, 1'b0, 5'd31, 32'h0,        32'h1234, 32'd0, 32'd0};
        vecs[2] = '{15'h1C03, 1'b0, 1'b0, 1'b0, 32'h5555, 32'h0,        15'h1C03, 1'b1, 5'd3,  32'h1234,     32'h5555, 32'd0, 32'd0};
        vecs[3] = '{15'h1C03, 1'b0, 1'b1, 1'b0, 32'h7777, 32'hDEADBEEF, 15'h7C00, 1'b1, 5'd5,  32'hDEADBEEF, 32'h7777, 32'd1, 32'd1};
        vecs[4] = '{15'h1C03, 1'b0, 1'b1, 1'b0, 32'h0,    32'h0,        15'h7C00, 1'b1, 5'd7,  32'h7777,     32'h0,    32'd2, 32'd2};
        vecs[5] = '{15'h1C03, 1'b0, 1'b1, 1'b1, 32'h0,    32'h0,        15'h7C00, 1'b0, 5'd31, 32'h0,        32'h0,    32'd3, 32'd3};
        vecs[6] = '{15'h2404, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        15'h2404, 1'b0, 5'd31, 32'h0,        32'h0,    32'd3, 32'd3};
        vecs[7] = '{15'h0C01, 1'b0, 1'b0, 1'b0, 32'hAAAA, 32'h0,        15'h0C01, 1'b0, 5'd31, 32'h0,        32'hAAAA, 32'd3, 32'd3};
        vecs[8] = '{TB_IDLE,  1'b0, 1'b0, 1'b0, 32'h1111, 32'h0,        15'h7C00, 1'b1, 5'd9,  32'hAAAA,     32'h1111, 32'd3, 32'd3};

        // Reset with stall/annul active to show reset dominates.
        rst            = 1'b1;
        bus.dec_ir     = 15'h0C01;
        bus.dec_is_ld  = 1'b0;
        bus.stall      = 1'b1;
        bus.annul      = 1'b1;
        bus.alu_result = 32'h0;
        bus.mem_rdata  = 32'h0;
        clockEdge();
        clockEdge();
        checkOutput();

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(TB_IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            clockEdge();
        end
        compareValue("idle_we", {31'd0, bus.we}, 32'd0);
        compareValue("idle_ir_wb", {17'd0, bus.ir_wb}, {17'd0, TB_BUBBLE});
        compareValue("idle_retired", bus.retired, 32'd0);
        compareValue("idle_bubbles", bus.bubbles, 32'd0);

        // Directed table.
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].dec_ir, vecs[v].is_ld, vecs[v].stall, vecs[v].annul,
                          vecs[v].alu, vecs[v].rdata, 1'b0);
            clockEdge();
            compareValue($sformatf("vec%0d_ir_exec", v), {17'd0, bus.ir_exec}, {17'd0, vecs[v].e_ir_exec});
            compareValue($sformatf("vec%0d_we", v), {31'd0, bus.we}, {31'd0, vecs[v].e_we});
            compareValue($sformatf("vec%0d_wa", v), {27'd0, bus.wa}, {27'd0, vecs[v].e_wa});
            compareValue($sformatf("vec%0d_wd", v), bus.wd, vecs[v].e_wd);
            compareValue($sformatf("vec%0d_mem_bypass", v), bus.mem_bypass, vecs[v].e_mem);
            compareValue($sformatf("vec%0d_retired", v), bus.retired, vecs[v].e_retired);
            compareValue($sformatf("vec%0d_bubbles", v), bus.bubbles, vecs[v].e_bubbles);
            checkOutput();
        end
        compareValue("vec_ld_wb_seen", {31'd0, bus.op_ld_or_ldr_wb}, 32'd0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            logic [14:0] ir;
            ir[9:0]   = 10'($urandom);
            ir[14:10] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            applyStimulus(ir, 1'($urandom), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 7) == 0), $urandom, $urandom,
                          ($urandom_range(0, 39) == 0));
            clockEdge();
            checkOutput();
        end

        // Reset with three valid instructions in flight.
        applyStimulus(TB_IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        clockEdge();
        applyStimulus(15'h0401, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0);
        clockEdge();
        applyStimulus(15'h0802, 1'b1, 1'b0, 1'b0, 32'h11, 32'h0, 1'b0);
        clockEdge();
        applyStimulus(15'h1003, 1'b0, 1'b0, 1'b0, 32'h22, 32'h0, 1'b0);
        clockEdge();
        compareValue("inflight_ir_wb", {17'd0, bus.ir_wb}, 32'h0401);
        applyStimulus(15'h1404, 1'b0, 1'b1, 1'b1, 32'h33, 32'h55, 1'b1);
        clockEdge();
        checkOutput();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(TB_IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h66, 1'b0);
            clockEdge();
            compareValue($sformatf("post_reset_we%0d", i), {31'd0, bus.we}, 32'd0);
            compareValue($sformatf("post_reset_retired%0d", i), bus.retired, 32'd0);
            compareValue($sformatf("post_reset_bubbles%0d", i), bus.bubbles, 32'd0);
            checkOutput();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
